muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit_if.sv | 27 ++
 rtl/muldiv_unit.sv | 134 +++++++++++++
 tb/tb_muldiv_unit.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request and register-file write-back bundle of the multiply/divide unit
// The core drives the request side (master); the unit answers with status and write-back (slave).
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            kill;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [4:0]      rd;
  logic            busy;
  logic            done;
  logic            we;
  logic [4:0]      wa;
  logic [XLEN-1:0] wd;

  modport master (
    output start, kill, funct3, a, b, rd,
    input  busy, done, we, wa, wd
  );

  modport slave (
    input  start, kill, funct3, a, b, rd,
    output busy, done, we, wa, wd
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit, fixed 33-cycle latency
// One 64-bit accumulator serves as product (shift-add) or {remainder, quotient} (restoring divide).
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [XLEN-1:0]   wd_q, wd_d;
  logic [4:0]        wa_q, wa_d;

  logic              sign_a, sign_b, a_neg, b_neg, b_zero;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, acc_nx, prod;
  logic [XLEN-1:0]   quo, rem, result;

  assign sign_a = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                  (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
  assign sign_b = (bus.funct3 == 3'b001) || (bus.funct3[2] && !bus.funct3[0]);
  assign a_neg  = sign_a && bus.a[XLEN-1];
  assign b_neg  = sign_b && bus.b[XLEN-1];
  assign b_zero = (bus.b == '0);
  assign mag_a  = a_neg ? -bus.a : bus.a;
  assign mag_b  = b_neg ? -bus.b : bus.b;

  // Multiply: add multiplicand into the high half when the low bit is set, then shift right.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Divide: trial-subtract the divisor from the remainder shifted by one dividend bit.
  assign div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};
  assign div_next = div_diff[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                   : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  assign acc_nx = op_q[2] ? div_next : mul_next;
  assign prod   = neg_q ? -acc_nx : acc_nx;
  assign quo    = neg_q ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
  assign rem    = rneg_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];

  always_comb begin
    result = '0;
    case (op_q)
      3'b000:         result = prod[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         result = prod[2*XLEN-1:XLEN];
      3'b100, 3'b101: result = quo;
      default:        result = rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    rd_d    = rd_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    wd_d    = wd_q;
    wa_d    = wa_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.kill) begin
          op_d    = bus.funct3;
          rd_d    = bus.rd;
          opb_d   = mag_b;
          acc_d   = {{XLEN{1'b0}}, mag_a};
          // A zero divisor must yield an all-ones quotient regardless of the dividend sign.
          neg_d   = (a_neg ^ b_neg) && !(bus.funct3[2] && b_zero);
          rneg_d  = a_neg;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_nx;
        cnt_d = cnt_q + 6'd1;
        if (bus.kill) begin
          state_d = S_IDLE;
        end else if (cnt_q == 6'd31) begin
          wd_d    = result;
          wa_d    = rd_q;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      rd_q    <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      wd_q    <= '0;
      wa_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      rd_q    <= rd_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      wd_q    <= wd_d;
      wa_q    <= wa_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.we   = (state_q == S_DONE);
  assign bus.wa   = wa_q;
  assign bus.wd   = wd_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed and random checks of muldiv_unit against an arithmetic model
// Inputs change on the falling edge; outputs are sampled there too.
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [31:0] last_wd = '0;
  logic [4:0]  last_wa = '0;

  muldiv_unit_if bus ();
  muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy, p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    p  = 0;
    case (f3)
      3'd0: begin p = sx * sy; return p[31:0]; end
      3'd1: begin p = sx * sy; return p[63:32]; end
      3'd2: begin p = sx * uy; return p[63:32]; end
      3'd3: begin p = ux * uy; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sx / sy; return p[31:0];
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        p = sx % sy; return p[31:0];
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge with the unit idle; that cycle is cycle 0. Returns in cycle 34.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] av,
                        input logic [31:0] bv, input logic [4:0] rdv, input logic [31:0] exp,
                        input bit poke);
    int bad;
    bad = 0;
    bus.start = 1'b1; bus.kill = 1'b0;
    bus.funct3 = f3; bus.a = av; bus.b = bv; bus.rd = rdv;
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      bus.start = poke && (c == 5);
      bus.a = $urandom; bus.b = $urandom; bus.rd = 5'($urandom); bus.funct3 = 3'($urandom);
      if (bus.busy !== 1'b1 || bus.we !== 1'b0 || bus.done !== 1'b0) bad++;
      if (bus.wd !== last_wd || bus.wa !== last_wa) bad++;
    end
    check({tag, " run"}, 32'(bad), 32'd0);
    @(negedge clk);
    bus.start = poke;
    check({tag, " busy33"}, 32'(bus.busy), 32'd1);
    check({tag, " we33"}, {30'd0, bus.we, bus.done}, 32'd3);
    check({tag, " wa"}, 32'(bus.wa), 32'(rdv));
    check({tag, " wd"}, bus.wd, exp);
    last_wd = exp;
    last_wa = rdv;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, " idle34"}, {29'd0, bus.busy, bus.we, bus.done}, 32'd0);
  endtask

  task automatic watch_no_we(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus.we !== 1'b0 || bus.busy !== 1'b0) seen++;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] ra, rb;
    bus.start = 1'b0; bus.kill = 1'b0; bus.funct3 = '0;
    bus.a = '0; bus.b = '0; bus.rd = '0;
    #12;
    check("reset outs", {27'd0, bus.busy, bus.done, bus.we, 2'b00}, 32'd0);
    check("reset wd", bus.wd, 32'd0);
    check("reset wa", 32'(bus.wa), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op("mul7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'h0000_0000, 1'b0);
    run_op("mulhsu", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd7, 32'h8000_0000, 1'b1);
    run_op("mulhu", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h7FFF_FFFF, 1'b0);
    run_op("div-7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, 1'b0);
    run_op("rem-7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, 1'b0);
    run_op("divu100/7", 3'd5, 32'd100, 32'd7, 5'd11, 32'd14, 1'b0);
    run_op("remu100/7", 3'd7, 32'd100, 32'd7, 5'd12, 32'd2, 1'b0);
    run_op("divu/0", 3'd5, 32'd5, 32'd0, 5'd13, 32'hFFFF_FFFF, 1'b0);
    run_op("remu/0", 3'd7, 32'd5, 32'd0, 5'd14, 32'd5, 1'b0);
    run_op("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1'b0);
    run_op("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0, 1'b1);
    run_op("div-5/0", 3'd4, 32'hFFFF_FFFB, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0);
    run_op("rem-5/0", 3'd6, 32'hFFFF_FFFB, 32'd0, 5'd17, 32'hFFFF_FFFB, 1'b0);

    // kill at cycle 10: idle at cycle 11 and no write-back ever
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.a = 32'd3; bus.b = 32'd4; bus.rd = 5'd20;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.kill = 1'b1;
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill idle11", 32'(bus.busy), 32'd0);
    watch_no_we("kill no we", 30);
    check("kill wd hold", bus.wd, last_wd);

    // kill together with start in idle: nothing accepted
    bus.start = 1'b1; bus.kill = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.kill = 1'b0;
    watch_no_we("kill+start", 36);

    // kill during DONE still writes back
    bus.start = 1'b1; bus.funct3 = 3'd5; bus.a = 32'd90; bus.b = 32'd9; bus.rd = 5'd21;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    bus.kill = 1'b1;
    check("kill done we", {30'd0, bus.we, bus.done}, 32'd3);
    check("kill done wd", bus.wd, 32'd10);
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill done idle", 32'(bus.busy), 32'd0);
    last_wd = 32'd10; last_wa = 5'd21;

    // back-to-back: second op starts in cycle 34, result in cycle 67
    run_op("b2b first", 3'd0, 32'd12, 32'd12, 5'd22, 32'd144, 1'b0);
    run_op("b2b second", 3'd5, 32'd1000, 32'd10, 5'd23, 32'd100, 1'b0);

    // asynchronous reset at cycle 20
    bus.start = 1'b1; bus.funct3 = 3'd0; bus.a = 32'd5; bus.b = 32'd5; bus.rd = 5'd24;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    #1;
    check("rst mid outs", {27'd0, bus.busy, bus.done, bus.we, 2'b00}, 32'd0);
    check("rst mid wd", bus.wd, 32'd0);
    check("rst mid wa", 32'(bus.wa), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    last_wd = '0; last_wa = '0;
    watch_no_we("rst no we", 20);
    @(negedge clk);

    for (int i = 0; i < 24; i++) begin
      f3 = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: ra = 32'h8000_0000;
        default: ;
      endcase
      run_op($sformatf("rand%0d f%0d", i, f3), f3, ra, rb, 5'($urandom), ref_model(f3, ra, rb), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
